// File: rtl/seq_detector_1010.sv
// seq_detector_1010: non-overlapping Mealy detector for the serial pattern 1-0-1-0
module seq_detector_1010 (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic z
);
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_e;
    state_e state_q, state_d;
    // State register; reset returns to idle without waiting for a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S0;
        else        state_q <= state_d;
    end
    // Next state and detect flag; a match restarts from idle so no bits are reused
    always_comb begin
        state_d = S0;
        z       = 1'b0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S1 : S2;
            S2:      state_d = x ? S3 : S0;
            S3: begin
                state_d = x ? S1 : S0;
                z       = ~x;
            end
            default: state_d = S0;
        endcase
    end
endmodule

// File: tb/tb_seq_detector_1010.sv
// tb_seq_detector_1010: directed and random checks of the 1010 detector against a bit-history model
`timescale 1ns/1ps
module tb_seq_detector_1010;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0;
    logic z;
    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    logic [2:0] h = 3'b000;

    seq_detector_1010 dut (.clk(clk), .rst_n(rst_n), .x(x), .z(z));

    always #5 clk = ~clk;

    function automatic logic exp_z(input logic b);
        return (n >= 3) && ({h, b} == 4'b1010);
    endfunction

    task automatic chk(input string tag, input logic o, input logic e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: z=%b expected %b at %0t", tag, o, e, $time);
        end
    endtask

    task automatic upd(input logic b, input logic e);
        n = e ? 0 : n + 1;
        h = {h[1:0], b};
    endtask

    task automatic step(input string tag, input logic b, input bit rst_pulse);
        logic e;
        @(negedge clk);
        x = b;
        if (rst_pulse) begin
            #1 chk({tag, "_pre_rst"}, z, exp_z(b));
            rst_n = 1'b0;
            #1 chk({tag, "_rst_low"}, z, 1'b0);
            x = ~b;
            #1 chk({tag, "_rst_low_xtog"}, z, 1'b0);
            x = b;
            rst_n = 1'b1;
            n = 0;
        end
        e = exp_z(b);
        #1 chk(tag, z, e);
        upd(b, e);
    endtask

    task automatic run(input string tag, input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) step(tag, bits[i], 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = i[0];
            #2 chk("reset_hold", z, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        run("basic", 16'b10100, 5);
        run("nonoverlap", 16'b101010, 6);
        run("s3_restart", 16'b1011010, 7);
        run("long", 16'b110101011101010, 15);
        run("idle_gap", 16'b0000, 4);
        run("mid_rst_pre", 16'b101, 3);
        step("mid_rst", 1'b0, 1'b1);
        run("post_rst", 16'b1010, 4);
        for (int i = 0; i < 600; i++) begin
            logic b;
            b = ($urandom_range(0, 2) != 0) ? ~h[0] : h[0];
            step("random", b, $urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
